// File: rtl/eq_regmap_pkg.sv
// Shared register-map constants and FSM encoding for the EQ gain writer.
// The band-to-address mapping lives here so every map client agrees on it.
package eq_regmap_pkg;

  localparam int         GAIN_WIDTH     = 24;
  localparam int         NUM_BANDS      = 10;
  localparam logic [7:0] CONFIG_ADDR    = 8'h00;
  localparam int         BYTES_PER_GAIN = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  // Band k (1..NUM_BANDS) occupies bytes 3k-2 .. 3k, LSB at the lowest address.
  function automatic logic [7:0] band_base_addr(input logic [3:0] band);
    return 8'(BYTES_PER_GAIN * int'(band) - 2);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: grants the requester not served last,
// and a lone requester is granted regardless of the pointer.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic prio_b;

  // NOTE: every combinational output is given a default first so no latch is inferred.
  always_comb begin
    grant = 2'b00;
    if (req[0] && (!req[1] || !prio_b)) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_b <= 1'b0;
    end else if (advance) begin
      prio_b <= grant[0];
    end
  end

endmodule

// File: rtl/gain_write_ctrl.sv
// Serialises gain updates from two requesters into byte writes on the EQ
// register map: one byte for the config band, three LSB-first for gain bands.
module gain_write_ctrl #(
  parameter int GAIN_WIDTH = eq_regmap_pkg::GAIN_WIDTH,
  parameter int NUM_BANDS  = eq_regmap_pkg::NUM_BANDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [3:0]            a_band,
  input  logic [GAIN_WIDTH-1:0] a_value,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [3:0]            b_band,
  input  logic [GAIN_WIDTH-1:0] b_value,
  output logic                  we,
  output logic [7:0]            addr,
  output logic [7:0]            data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  import eq_regmap_pkg::*;

  localparam logic [3:0] MAX_BAND  = 4'(NUM_BANDS);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_GAIN - 1);

  state_t                state, state_d;
  logic [1:0]            cnt, cnt_d, last, last_d, cnt_nx;
  logic [GAIN_WIDTH-1:0] val, val_d, sel_value;
  logic [3:0]            sel_band;
  logic [7:0]            addr_d, data_d;
  logic                  we_d, busy_d, done_d, err_d;
  logic                  armed, armed_d;
  logic [1:0]            grant;
  logic                  accept;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({b_valid, a_valid}),
    .advance(accept),
    .grant  (grant)
  );

  // armed is a registered copy of "in IDLE" that stays low through reset,
  // so ready can never be seen while rst is asserted.
  assign a_ready   = armed & grant[0];
  assign b_ready   = armed & grant[1];
  assign accept    = (a_valid & a_ready) | (b_valid & b_ready);
  assign sel_band  = grant[1] ? b_band  : a_band;
  assign sel_value = grant[1] ? b_value : a_value;
  assign cnt_nx    = cnt + 2'd1;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    last_d  = last;
    val_d   = val;
    addr_d  = addr;
    data_d  = data_in;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (sel_band <= MAX_BAND) begin
            state_d = WRITE;
            cnt_d   = 2'd0;
            val_d   = sel_value;
            data_d  = sel_value[7:0];
            we_d    = 1'b1;
            busy_d  = 1'b1;
            if (sel_band == 4'd0) begin
              last_d = 2'd0;
              addr_d = CONFIG_ADDR;
            end else begin
              last_d = LAST_BYTE;
              addr_d = band_base_addr(sel_band);
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WRITE: begin
        if (cnt == last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_nx;
          addr_d = addr + 8'd1;
          data_d = 8'(val >> {cnt_nx, 3'b000});
          we_d   = 1'b1;
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    armed_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      last    <= 2'd0;
      val     <= '0;
      addr    <= 8'h00;
      data_in <= 8'h00;
      we      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      armed   <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      last    <= last_d;
      val     <= val_d;
      addr    <= addr_d;
      data_in <= data_d;
      we      <= we_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
      armed   <= armed_d;
    end
  end

endmodule

// File: tb/tb_gain_write_ctrl.sv
// Directed bench for gain_write_ctrl: a vector table of single requests plus
// hand-written round-robin, mid-write reset and value-hold sequences.
module tb_gain_write_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [3:0]  a_band, b_band;
  logic [23:0] a_value, b_value;
  logic        we, busy, done, err;
  logic [7:0]  addr, data_in;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        use_b;
    logic [3:0]  band;
    logic [23:0] value;
    int          n;
    logic [7:0]  addr0;
    logic [23:0] bytes;   // {byte2, byte1, byte0} in write order LSB first
    logic        err;
  } vec_t;

  vec_t vecs [9];

  gain_write_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .a_valid(a_valid),
    .a_ready(a_ready),
    .a_band (a_band),
    .a_value(a_value),
    .b_valid(b_valid),
    .b_ready(b_ready),
    .b_band (b_band),
    .b_value(b_value),
    .we     (we),
    .addr   (addr),
    .data_in(data_in),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    logic got;
    @(negedge clk);
    if (v.use_b) begin
      b_valid = 1'b1; b_band = v.band; b_value = v.value;
    end else begin
      a_valid = 1'b1; a_band = v.band; a_value = v.value;
    end
    got = 1'b0;
    for (int w = 0; w < 20; w++) begin
      #1;
      if (v.use_b ? b_ready : a_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check($sformatf("v%0d_accept", idx), 32'(got), 32'd1);
    if (!got) begin
      a_valid = 1'b0; b_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    // Scramble the inputs right after acceptance; the writes must not follow.
    a_valid = 1'b0; b_valid = 1'b0;
    a_value = ~v.value; b_value = ~v.value;
    a_band  = 4'd3;     b_band  = 4'd3;
    #1;
    for (int i = 0; i < v.n; i++) begin
      check($sformatf("v%0d_we_%0d", idx, i),   32'(we),      32'd1);
      check($sformatf("v%0d_addr_%0d", idx, i), 32'(addr),    32'(v.addr0) + 32'(i));
      check($sformatf("v%0d_data_%0d", idx, i), 32'(data_in), 32'(v.bytes[8*i +: 8]));
      check($sformatf("v%0d_busy_%0d", idx, i), 32'(busy),    32'd1);
      check($sformatf("v%0d_nodone_%0d", idx, i), 32'(done), 32'd0);
      @(negedge clk);
      #1;
    end
    check($sformatf("v%0d_err", idx),  32'(err),  32'(v.err));
    check($sformatf("v%0d_done", idx), 32'(done), 32'(!v.err));
    check($sformatf("v%0d_we_end", idx),   32'(we),   32'd0);
    check($sformatf("v%0d_busy_end", idx), 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    check($sformatf("v%0d_done_once", idx), 32'(done), 32'd0);
    check($sformatf("v%0d_err_once", idx),  32'(err),  32'd0);
  endtask

  logic [0:0] exp_b    [4];
  logic [7:0] exp_addr [12];
  logic [7:0] exp_data [12];

  initial begin
    int  g, wc;
    logic got, done_seen, we_seen;

    vecs[0] = '{1'b0, 4'd2,  24'h1C71C7, 3, 8'd4,  24'h1C71C7, 1'b0};
    vecs[1] = '{1'b0, 4'd0,  24'h0000AA, 1, 8'd0,  24'h0000AA, 1'b0};
    vecs[2] = '{1'b1, 4'd12, 24'h123456, 0, 8'd0,  24'h000000, 1'b1};
    vecs[3] = '{1'b1, 4'd10, 24'hABCDEF, 3, 8'd28, 24'hABCDEF, 1'b0};
    vecs[4] = '{1'b0, 4'd1,  24'h00FF01, 3, 8'd1,  24'h00FF01, 1'b0};
    vecs[5] = '{1'b0, 4'd11, 24'h777777, 0, 8'd0,  24'h000000, 1'b1};
    vecs[6] = '{1'b1, 4'd0,  24'h5A5A37, 1, 8'd0,  24'h000037, 1'b0};
    vecs[7] = '{1'b1, 4'd15, 24'h010203, 0, 8'd0,  24'h000000, 1'b1};
    vecs[8] = '{1'b1, 4'd9,  24'h0A0B0C, 3, 8'd25, 24'h0A0B0C, 1'b0};

    exp_b = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_addr = '{8'd28, 8'd29, 8'd30, 8'd1, 8'd2, 8'd3,
                 8'd28, 8'd29, 8'd30, 8'd1, 8'd2, 8'd3};
    exp_data = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00,
                 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};

    // Reset state, with both requesters already asking.
    rst = 1'b1;
    a_valid = 1'b1; a_band = 4'd1; a_value = 24'h111111;
    b_valid = 1'b1; b_band = 4'd2; b_value = 24'h222222;
    #1;
    check("rst_we",      32'(we),      32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_err",     32'(err),     32'd0);
    check("rst_addr",    32'(addr),    32'd0);
    check("rst_data",    32'(data_in), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    #20;
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 9; k++) apply_vec(k, vecs[k]);

    // Both requesters held valid from reset: grants alternate starting with A.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    a_valid = 1'b1; a_band = 4'd10; a_value = 24'hFFFFFF;
    b_valid = 1'b1; b_band = 4'd1;  b_value = 24'h000000;
    g = 0; wc = 0;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (a_ready || b_ready) begin
        check("rr_ready_excl", 32'(a_ready & b_ready), 32'd0);
        check("rr_no_overlap", 32'(we), 32'd0);
        if (g < 4) check($sformatf("rr_grant_%0d", g), 32'(b_ready), 32'(exp_b[g]));
        g++;
      end
      if (we) begin
        if (wc < 12) begin
          check($sformatf("rr_addr_%0d", wc), 32'(addr),    32'(exp_addr[wc]));
          check($sformatf("rr_data_%0d", wc), 32'(data_in), 32'(exp_data[wc]));
        end
        wc++;
      end
      @(negedge clk);
    end
    check("rr_grants_seen", 32'(g >= 4),  32'd1);
    check("rr_writes_seen", 32'(wc >= 12), 32'd1);
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Reset during the second byte of a band 5 write aborts it.
    a_valid = 1'b1; a_band = 4'd5; a_value = 24'h3C2D1E;
    got = 1'b0;
    for (int w = 0; w < 20; w++) begin
      #1;
      if (a_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("abort_accept", 32'(got), 32'd1);
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    check("abort_addr0", 32'(addr),    32'd13);
    check("abort_data0", 32'(data_in), 32'h1E);
    @(negedge clk);
    #1;
    check("abort_we1",   32'(we),      32'd1);
    check("abort_addr1", 32'(addr),    32'd14);
    rst = 1'b1;
    #1;
    check("abort_we_drop",   32'(we),      32'd0);
    check("abort_busy_drop", 32'(busy),    32'd0);
    check("abort_addr_rst",  32'(addr),    32'd0);
    check("abort_data_rst",  32'(data_in), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 1'b0; we_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      done_seen |= done;
      we_seen   |= we;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_no_we",   32'(we_seen),   32'd0);
    apply_vec(9, '{1'b0, 4'd5, 24'h654321, 3, 8'd13, 24'h654321, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gain_write_ctrl.md
GAIN_WRITE_CTRL -- requirements
Module: gain_write_ctrl

Interface
REQ-001 SHALL have parameter GAIN_WIDTH, default 24, meaning the width of a gain word.
REQ-002 SHALL have parameter NUM_BANDS, default 10, meaning the number of gain bands in the register map.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports a_valid (input, 1), a_ready (output, 1), a_band (input, 4), a_value (input, GAIN_WIDTH): requester A.
REQ-006 SHALL have ports b_valid, b_ready, b_band, b_value, with the same widths: requester B.
REQ-007 SHALL have port we, output, 1 bit: register-map write strobe.
REQ-008 SHALL have port addr, output, 8 bits: register-map byte address.
REQ-009 SHALL have port data_in, output, 8 bits: register-map write byte.
REQ-010 SHALL have port busy, output, 1 bit: high while a request is being written.
REQ-011 SHALL have port done, output, 1 bit: 1-cycle pulse when a request completes.
REQ-012 SHALL have port err, output, 1 bit: 1-cycle pulse when a request is rejected.

Function
REQ-013 SHALL accept a request when valid && ready is true on a rising clk edge.
REQ-014 SHALL capture band and value on acceptance; later input changes SHALL have no effect on the writes.
REQ-015 SHALL assert a_ready or b_ready only in IDLE, and SHALL never assert both in the same cycle.
REQ-016 SHALL arbitrate round-robin: when both valid, grant the requester not served last; after reset A has priority.
REQ-017 SHALL, when only one requester is valid, grant it regardless of the round-robin pointer.
REQ-018 SHALL, for band 0 (configuration), perform one write: addr=0, data_in=value[7:0].
REQ-019 SHALL, for band k in 1..NUM_BANDS, perform three writes LSB first: addr 3k-2 gets value[7:0], 3k-1 gets [15:8], 3k gets [23:16].
REQ-020 SHALL, for band > NUM_BANDS, accept the request, perform no write, pulse err in cycle T+1, and return to IDLE.
REQ-021 SHALL use FSM states IDLE -> WRITE (byte counter 0..2) -> IDLE.
REQ-022 SHALL, for a request accepted at edge T, drive we high with registered addr/data_in during cycles T+1..T+n (n = 1 or 3, consecutive), then return to IDLE.
REQ-023 SHALL drive busy high exactly during the write cycles.
REQ-024 SHALL pulse done in cycle T+n+1; ready MAY assert in that same cycle, giving a throughput of one gain per 4 cycles.
REQ-025 SHALL hold we low outside WRITE; addr/data_in are don't-care when we is low but SHALL hold their last value.

Reset
REQ-026 SHALL, on rst high, immediately force we, busy, done, err, a_ready and b_ready to 0, addr and data_in to 0x00, state to IDLE, and the round-robin pointer to A.
REQ-027 SHALL, on reset mid-WRITE, abort the request: remaining bytes are not written and no done pulse is produced.
REQ-028 SHALL accept the first request no earlier than the first rising edge after rst deasserts.

Structure
REQ-029 SHALL take GAIN_WIDTH, NUM_BANDS, CONFIG_ADDR=0, BYTES_PER_GAIN=3 and the FSM state encoding from the shared package eq_regmap_pkg.
REQ-030 SHALL implement the two-way round-robin grant in the sub-module rr_arbiter2 (inputs req[1:0] and advance; output grant[1:0]).
REQ-031 SHALL register all outputs (no combinational input-to-output paths), except a_ready and b_ready, which are decoded from state and grant.

Verification
REQ-032 SHALL cover: A writes band 2, value 0x1C71C7 -> we high 3 cycles with addr 4/5/6 and data C7/71/1C, then done pulses once.
REQ-033 SHALL cover: A writes band 0, value 0x0000AA -> exactly one write, addr 0, data AA, done pulses in T+2.
REQ-034 SHALL cover: A and B both valid continuously (A band 10 = 0xFFFFFF, B band 1 = 0x000000) -> grant order A, B, A, B; no write overlap; addr 28-30 then 1-3.
REQ-035 SHALL cover: B writes band 12 -> err pulses once, we stays low, done stays low.
REQ-036 SHALL cover: rst asserted during the second byte of band 5 -> we drops immediately, no done pulse; a new band 5 request after reset writes addr 13/14/15 correctly.
REQ-037 SHALL cover: a_value changed the cycle after acceptance -> the written bytes match the value captured at acceptance.
